mdsa_stream_adapter: RTL and testbench
======================================

Name: mdsa_stream_adapter

Overview:
- Parametrised element-stream front/back end for the MDSA sorter core.
- Packs ROWS*COLS elements of DATA_W bits, arriving one per valid/ready beat, into one frame, then launches the sorter with start/en.
- Waits for the sorter's rdy/output_enable, captures the sorted frame, and streams it back out element by element with a last flag.
- Replaces direct wide-bus driving of the sorter by the testbench/SoC. Geometry is generalised; the default geometry equals the existing 2048-bit sorter frame.

Parameters:
- DATA_W, 8, element width in bits.
- ROWS, 16, matrix rows.
- COLS, 16, matrix columns. N = ROWS*COLS (localparam, must be >= 2).
- FRAME_W = DATA_W*N, localparam (default 2048).
- CNT_W, 16, width of frame_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_valid  in  1  input element valid.
- s_data  in  DATA_W  input element.
- s_ready  out  1  adapter accepts element.
- m_valid  out  1  output element valid.
- m_data  out  DATA_W  sorted output element.
- m_last  out  1  marks element N-1 of a frame.
- m_ready  in  1  downstream accepts element.
- srt_start  out  1  one-cycle start pulse to sorter.
- srt_en  out  1  sorter enable.
- srt_data_in  out  FRAME_W  packed frame to sorter.
- srt_rdy  in  1  sorter done.
- srt_oe  in  1  sorter output_enable.
- srt_data_out  in  FRAME_W  sorted frame from sorter.
- busy  out  1  frame in progress.
- frame_cnt  out  CNT_W  completed frames, wraps modulo 2^CNT_W.
- err  out  1  timeout pulse (tied 0 unless macro defined).

Behaviour:
- Reset (rst=0, asynchronous):
  - State LOAD, idx=0.
  - All outputs 0: s_ready, m_valid, m_last, srt_start, srt_en, busy, err, frame_cnt, m_data, srt_data_in.
  - Frame and capture registers cleared.
- Element ordering: element k occupies bits [k*DATA_W +: DATA_W] in both directions. Element 0 is the first beat in and the first beat out.
- LOAD:
  - s_ready=1.
  - On s_valid&&s_ready, store s_data at slot idx and increment idx.
  - Acceptance of slot N-1: idx<=0, go to KICK.
- KICK (exactly 1 cycle):
  - srt_start=1, srt_en=1; srt_data_in = frame register.
  - srt_data_in stays stable from KICK until capture.
  - Go to WAIT.
- WAIT:
  - srt_en=1, srt_start=0.
  - First cycle srt_rdy&&srt_oe is sampled high: srt_data_out is captured into the output register, srt_en drops next cycle, go to UNLOAD.
- UNLOAD:
  - m_valid=1, m_data = output slot idx, m_last=(idx==N-1).
  - Advance idx on m_valid&&m_ready.
  - After the last transfer: m_valid=0, idx=0, frame_cnt++, go to LOAD.
- m_valid, m_data and m_last are registered. m_data and m_last hold stable while m_ready=0.
- s_ready=0 in KICK, WAIT and UNLOAD; s_valid is ignored there.
- srt_rdy/srt_oe outside WAIT (including during the KICK cycle) are ignored.
- First m_valid is asserted the cycle after capture.
- busy = (state != LOAD) || (idx != 0).
- Reset mid-operation discards any partial or in-flight frame. frame_cnt is cleared only by reset.

Optional Feature:
- Macro MDSA_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYC (default 4096) and a WAIT-state cycle counter, cleared on KICK.
  - If the counter reaches TIMEOUT_CYC without capture: err=1 for exactly one cycle, srt_en=0, frame discarded, frame_cnt unchanged, return to LOAD with idx=0.
- Undefined:
  - WAIT persists indefinitely.
  - err is constant 0 and no counter is synthesised.

Test Plan:
- Basic sort (defaults, N=256):
  - Stimulus: reset, feed 255..0; sorter model returns an ascending frame 10 cycles after start.
  - Response: srt_start high exactly 1 cycle, the cycle after the 256th accept; out 0..255 with m_last only on 255; frame_cnt=1.
- Backpressure:
  - Stimulus: m_ready pseudo-random 50% duty.
  - Response: 256 beats, no loss or duplication; m_data/m_last unchanged during every stalled cycle.
- Early done:
  - Stimulus: srt_rdy=srt_oe=1 held throughout LOAD and KICK.
  - Response: no capture before WAIT; capture on the first WAIT cycle; m_valid the next cycle.
- Reset mid-LOAD:
  - Stimulus: rst low after 100 accepts, then a full 256-element frame.
  - Response: all outputs 0 during reset; frame_cnt 0 then 1; output matches the second frame only.
- Back-to-back frames:
  - Stimulus: s_valid continuous for 3 frames.
  - Response: s_ready low from KICK through the end of UNLOAD; 3 correct sorted frames; frame_cnt=3.
- Timeout (MDSA_TIMEOUT_EN, TIMEOUT_CYC=64):
  - Stimulus: sorter never asserts rdy.
  - Response: err one-cycle pulse 64 cycles after entering WAIT; s_ready=1 next cycle; frame_cnt=0.
  - Without the macro: busy still 1 after 1000 cycles and err=0.

Source files
------------

// File: rtl/mdsa_stream_adapter.sv
// mdsa_stream_adapter: element-stream front/back end for the MDSA sorter core.
// Packs ROWS*COLS elements of DATA_W bits into one frame and launches the
// sorter with a one-cycle start pulse. It then waits for rdy/output_enable,
// captures the sorted frame and streams it back out with a last flag.
// Element k occupies bits [k*DATA_W +: DATA_W] in both directions.
// Optional macro MDSA_TIMEOUT_EN adds parameter TIMEOUT_CYC. A frame whose
// sorter never answers within TIMEOUT_CYC WAIT cycles is dropped with an err pulse.
// Without the macro, err is tied to 0.
module mdsa_stream_adapter #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 16,
    parameter int COLS   = 16,
    parameter int CNT_W  = 16
`ifdef MDSA_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    input  logic [DATA_W-1:0]             s_data,
    output logic                          s_ready,
    output logic                          m_valid,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_last,
    input  logic                          m_ready,
    output logic                          srt_start,
    output logic                          srt_en,
    output logic [DATA_W*ROWS*COLS-1:0]   srt_data_in,
    input  logic                          srt_rdy,
    input  logic                          srt_oe,
    input  logic [DATA_W*ROWS*COLS-1:0]   srt_data_out,
    output logic                          busy,
    output logic [CNT_W-1:0]              frame_cnt,
    output logic                          err
);

    // N must be at least 2, so element 0 is never the last element.
    localparam int N       = ROWS * COLS;
    localparam int FRAME_W = DATA_W * N;
    localparam int IDX_W   = $clog2(N);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_KICK   = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_UNLOAD = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FRAME_W-1:0] frame_q;
    logic [FRAME_W-1:0] cap_q;
    logic               s_ready_q;
    logic               m_valid_q;
    logic               m_last_q;
    logic [DATA_W-1:0]  m_data_q;
    logic [CNT_W-1:0]   frame_cnt_q;

    logic accept;
    logic xfer;
    logic capture;
    logic timeout;

    // s_ready_q is only ever high in LOAD, so it gates acceptance by itself.
    assign accept  = s_valid && s_ready_q;
    assign xfer    = m_valid_q && m_ready;
    assign capture = (state_q == ST_WAIT) && srt_rdy && srt_oe;

`ifdef MDSA_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    assign timeout = (state_q == ST_WAIT) && !capture
                     && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    // Count cycles spent in WAIT, restarting on every launch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
        end else if (state_q == ST_KICK) begin
            tmo_q <= '0;
        end else if (state_q == ST_WAIT) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    // One-cycle error pulse when the sorter failed to answer in time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // Next-state and element index for the LOAD/KICK/WAIT/UNLOAD sequence.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no latch is inferred.
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_KICK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_KICK: state_d = ST_WAIT;
            ST_WAIT: begin
                if (capture) begin
                    state_d = ST_UNLOAD;
                end else if (timeout) begin
                    state_d = ST_LOAD;
                end
            end
            ST_UNLOAD: begin
                if (xfer) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Control state, index and the registered input handshake.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            state_q   <= ST_LOAD;
            idx_q     <= '0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            s_ready_q <= (state_d == ST_LOAD);
        end
    end

    // Frame assembly from the input stream and capture of the sorted frame.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: frame and capture storage are plain flops cleared on reset, so a reset
        // cannot leak a stale frame to the sorter or the output stream.
        if (!rst) begin
            frame_q <= '0;
            cap_q   <= '0;
        end else begin
            if (accept) begin
                frame_q[int'(idx_q) * DATA_W +: DATA_W] <= s_data;
            end
            if (capture) begin
                cap_q <= srt_data_out;
            end
        end
    end

    // Registered output stream. Data and last only move on a transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else if (capture) begin
            m_valid_q <= 1'b1;
            m_data_q  <= srt_data_out[DATA_W-1:0];
            m_last_q  <= 1'b0;
        end else if ((state_q == ST_UNLOAD) && xfer) begin
            if (idx_q == IDX_LAST) begin
                m_valid_q   <= 1'b0;
                m_last_q    <= 1'b0;
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end else begin
                m_data_q <= cap_q[int'(idx_d) * DATA_W +: DATA_W];
                m_last_q <= (idx_d == IDX_LAST);
            end
        end
    end

    assign s_ready     = s_ready_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_last      = m_last_q;
    assign srt_start   = (state_q == ST_KICK);
    assign srt_en      = (state_q == ST_KICK) || (state_q == ST_WAIT);
    assign srt_data_in = frame_q;
    assign busy        = (state_q != ST_LOAD) || (idx_q != '0);
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_mdsa_stream_adapter.sv
// Scoreboard testbench for mdsa_stream_adapter (default geometry, N=256).
// A driver issues frames and pushes the expected sorted stream into a queue.
// A monitor pops and compares on every output transfer and checks timing and stalls.
// A behavioural sorter model answers srt_start in three modes:
// normal (10 cycles), early (rdy held high), or never.
module tb_mdsa_stream_adapter;

    localparam int DATA_W  = 8;
    localparam int ROWS    = 16;
    localparam int COLS    = 16;
    localparam int CNT_W   = 16;
    localparam int N       = ROWS * COLS;
    localparam int FRAME_W = DATA_W * N;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               s_valid;
    logic [DATA_W-1:0]  s_data;
    logic               s_ready;
    logic               m_valid;
    logic [DATA_W-1:0]  m_data;
    logic               m_last;
    logic               m_ready;
    logic               srt_start;
    logic               srt_en;
    logic [FRAME_W-1:0] srt_data_in;
    logic               srt_rdy;
    logic               srt_oe;
    logic [FRAME_W-1:0] srt_data_out;
    logic               busy;
    logic [CNT_W-1:0]   frame_cnt;
    logic               err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int sorter_mode = 0;   // 0 normal, 1 early done, 2 never answers
    bit bp = 1'b0;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              last;
    } exp_t;
    exp_t exp_q[$];

    mdsa_stream_adapter #(
        .DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)
`ifdef MDSA_TIMEOUT_EN
        , .TIMEOUT_CYC(64)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .srt_start(srt_start), .srt_en(srt_en), .srt_data_in(srt_data_in),
        .srt_rdy(srt_rdy), .srt_oe(srt_oe), .srt_data_out(srt_data_out),
        .busy(busy), .frame_cnt(frame_cnt), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [FRAME_W-1:0] rand_frame();
        logic [FRAME_W-1:0] r;
        r = '0;
        for (int i = 0; i < FRAME_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Sorter model: counting sort of the packed frame.
    function automatic logic [FRAME_W-1:0] sort_frame(input logic [FRAME_W-1:0] f);
        int                 hist [2**DATA_W];
        int                 k;
        logic [FRAME_W-1:0] r;
        foreach (hist[v]) hist[v] = 0;
        for (int i = 0; i < N; i++) hist[int'(f[i*DATA_W +: DATA_W])]++;
        r = '0;
        k = 0;
        for (int v = 0; v < 2**DATA_W; v++) begin
            for (int c = 0; c < hist[v]; c++) begin
                r[k*DATA_W +: DATA_W] = DATA_W'(v);
                k++;
            end
        end
        return r;
    endfunction

    // Downstream ready: always on, or a random 50% duty under backpressure.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Behavioural sorter.
    logic [FRAME_W-1:0] pending;
    int                 dly;
    bit                 armed;
    initial begin
        srt_rdy = 1'b0; srt_oe = 1'b0; srt_data_out = '0;
        pending = '0; dly = 0; armed = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                armed = 1'b0;
            end else if (srt_start) begin
                pending = sort_frame(srt_data_in);
                dly     = 10;
                armed   = 1'b1;
            end else if (armed && !srt_en) begin
                armed = 1'b0;
            end else if (armed && dly > 0) begin
                dly--;
            end
            if (sorter_mode == 1) begin
                srt_rdy = 1'b1; srt_oe = 1'b1;
                srt_data_out = armed ? pending : rand_frame();
            end else if (sorter_mode == 0 && armed && dly == 0) begin
                srt_rdy = 1'b1; srt_oe = 1'b1; srt_data_out = pending;
            end else begin
                srt_rdy = 1'b0; srt_oe = 1'b0; srt_data_out = rand_frame();
            end
        end
    end

    // Monitor: reset values, start pulse timing, s_ready gating, stall stability, scoreboard.
    int                acc_cnt = 0;
    int                exp_start = -1;
    int                start_cyc = -100;
    bit                in_frame = 1'b0;
    bit                prev_v = 1'b0;
    bit                prev_r = 1'b0;
    logic [DATA_W-1:0] prev_d = '0;
    logic              prev_l = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_ctrl", {s_ready, m_valid, m_last, srt_start, srt_en, busy, err}, 64'd0);
                check("rst_data", {m_data, frame_cnt}, 64'd0);
                check("rst_srt_data_in", 64'(srt_data_in == '0), 64'd1);
                acc_cnt = 0; exp_start = -1; in_frame = 1'b0; prev_v = 1'b0;
            end else begin
                if (srt_start || cyc == exp_start) begin
                    check("srt_start_timing", 64'(srt_start), 64'(cyc == exp_start));
                    if (srt_start) start_cyc = cyc;
                end
                if (in_frame) check("s_ready_low", 64'(s_ready), 64'd0);
                if (prev_v && !prev_r) begin
                    check("stall_valid", 64'(m_valid), 64'd1);
                    check("stall_data", 64'(m_data), 64'(prev_d));
                    check("stall_last", 64'(m_last), 64'(prev_l));
                end
                if (m_valid && !prev_v)
                    check("first_valid_latency", 64'(cyc - start_cyc), (sorter_mode == 1) ? 64'd2 : 64'd11);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'(m_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", 64'(m_data), 64'(e.d));
                        check("m_last", 64'(m_last), 64'(e.last));
                        if (e.last) in_frame = 1'b0;
                    end
                end
                if (s_valid && s_ready) begin
                    acc_cnt++;
                    if (acc_cnt == N) begin
                        acc_cnt = 0; exp_start = cyc + 1; in_frame = 1'b1;
                    end
                end
                if (err) in_frame = 1'b0;
                prev_v = m_valid; prev_r = m_ready; prev_d = m_data; prev_l = m_last;
            end
        end
    end

    // Drive nsend elements (kind 0 random, 1 descending N-1..0); push the sorted expectation.
    task automatic send_frame(input int kind, input int nsend, input bit keep_valid);
        logic [DATA_W-1:0] el [N];
        int                q[$];
        int                w;
        for (int i = 0; i < N; i++)
            el[i] = (kind == 1) ? DATA_W'(N - 1 - i) : DATA_W'($urandom);
        for (int i = 0; i < nsend; i++) begin
            s_valid = 1'b1;
            s_data  = el[i];
            w = 0;
            @(negedge clk);
            while (!s_ready && w < 5000) begin
                @(negedge clk);
                w++;
            end
            check("accept_wait", 64'(s_ready), 64'd1);
            if (!s_ready) begin
                s_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        if (!keep_valid) s_valid = 1'b0;
        if (nsend == N && sorter_mode != 2) begin
            for (int i = 0; i < N; i++) q.push_back(int'(el[i]));
            q.sort();
            for (int i = 0; i < N; i++) exp_q.push_back('{d: DATA_W'(q[i]), last: (i == N - 1)});
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("idle_reached", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        s_valid = 1'b0;
        s_data  = '0;
        rst     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("frame_cnt_after_reset", 64'(frame_cnt), 64'd0);
        check("busy_after_reset", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // Basic descending frame.
        send_frame(1, N, 1'b0);
        wait_idle();
        check("frame_cnt_basic", 64'(frame_cnt), 64'd1);

        // Random frame under output backpressure.
        bp = 1'b1;
        send_frame(0, N, 1'b0);
        wait_idle();
        bp = 1'b0;
        check("frame_cnt_backpressure", 64'(frame_cnt), 64'd2);

        // Sorter claims done throughout LOAD and KICK.
        sorter_mode = 1;
        send_frame(0, N, 1'b0);
        wait_idle();
        sorter_mode = 0;
        check("frame_cnt_early", 64'(frame_cnt), 64'd3);

        // Reset after 100 accepts, then a complete frame.
        send_frame(0, 100, 1'b0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("frame_cnt_cleared", 64'(frame_cnt), 64'd0);
        @(posedge clk); #1;
        send_frame(0, N, 1'b0);
        wait_idle();
        check("frame_cnt_after_mid_reset", 64'(frame_cnt), 64'd1);

        // Three frames with s_valid held high throughout.
        for (int f = 0; f < 3; f++) send_frame(0, N, 1'b1);
        s_valid = 1'b0;
        wait_idle();
        check("frame_cnt_back_to_back", 64'(frame_cnt), 64'd4);

        // Sorter never answers.
        sorter_mode = 2;
        send_frame(0, N, 1'b0);
`ifdef MDSA_TIMEOUT_EN
        begin
            int w = 0;
            @(negedge clk);
            while (!err && w < 500) begin
                @(negedge clk);
                w++;
            end
            check("err_seen", 64'(err), 64'd1);
            check("err_timing", 64'(cyc - start_cyc), 64'd65);
            check("frame_cnt_timeout", 64'(frame_cnt), 64'd4);
            @(negedge clk);
            check("err_one_cycle", 64'(err), 64'd0);
            check("s_ready_after_timeout", 64'(s_ready), 64'd1);
            check("srt_en_after_timeout", 64'(srt_en), 64'd0);
            check("busy_after_timeout", 64'(busy), 64'd0);
        end
`else
        repeat (1000) @(negedge clk);
        check("busy_no_timeout", 64'(busy), 64'd1);
        check("err_tied_low", 64'(err), 64'd0);
        check("frame_cnt_stuck", 64'(frame_cnt), 64'd4);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
`endif
        sorter_mode = 0;
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
